// File: rtl/ad7928_sequencer.sv
// ad7928_sequencer
//
// SPI master and channel scheduler for the AD7928 8-channel 12-bit ADC.
// A free-running period counter requests conversion frames. Each frame
// writes a control word selecting the next enabled channel, round-robin.
// The word shifted back in is decoded into a one-cycle data/channel/valid
// pulse for the downstream averaging filter.
//
// Ports:
//   clk            system clock (single domain)
//   reset_n        asynchronous active-low reset
//   core_en        enables frame generation
//   ch_mask[7:0]   enabled channels, bit i = channel i
//   sample_period  clk cycles between frame starts (0/1 = back-to-back)
//   adc_range      RANGE bit written to the ADC
//   adc_coding     CODING bit written to the ADC
//   adc_cs_n       ADC chip select
//   adc_sclk       ADC serial clock, idles high
//   adc_din        serial control word to the ADC
//   adc_dout       serial result from the ADC
//   m_adc_data     converted sample
//   m_adc_chanel   channel tag taken from the returned word
//   m_axis_valid   one-cycle pulse marking a new sample
//   busy           high while a frame or its quiet time is in progress
//
// Optional feature, macro AD7928_SEQ_ADDR_CHECK_EN:
//   addr_err       sticky flag, returned address did not match what was
//                  written in the previous non-dummy frame (or bit 15 set)
//   addr_err_clr   clears addr_err; a simultaneous set wins

module ad7928_sequencer #(
  parameter int SCLK_DIV     = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    core_en,
  input  logic [7:0]              ch_mask,
  input  logic [PERIOD_WIDTH-1:0] sample_period,
  input  logic                    adc_range,
  input  logic                    adc_coding,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic                    adc_din,
  input  logic                    adc_dout,
  output logic [11:0]             m_adc_data,
  output logic [2:0]              m_adc_chanel,
  output logic                    m_axis_valid,
  output logic                    busy
`ifdef AD7928_SEQ_ADDR_CHECK_EN
  ,
  output logic                    addr_err,
  input  logic                    addr_err_clr
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic                    tick;
  logic                    tick_pending;
  logic                    start;
  logic                    core_en_d;
  logic [1:0]              dummy_cnt;
  logic                    is_dummy;
  logic [2:0]              rr_ptr;
  logic [2:0]              next_ch;
  logic [2:0]              scan_idx;
  logic                    found;
  logic [15:0]             ctrl_word;
  logic [15:0]             tx_word;
  logic [15:0]             rx_word;
  logic [7:0]              div_cnt;
  logic [4:0]              bit_cnt;
  logic [7:0]              quiet_cnt;

`ifdef AD7928_SEQ_ADDR_CHECK_EN
  logic [2:0]              cur_addr;
  logic [2:0]              prev_addr;
  logic                    prev_ok;
`else
  logic                    unused_rx_msb;
  assign unused_rx_msb = rx_word[15];
`endif

  // A period of 0 or 1 ticks every cycle; >= keeps the counter sane if
  // sample_period is lowered below the current count.
  assign tick = core_en &&
                ((sample_period <= PERIOD_WIDTH'(1)) ||
                 (period_cnt >= sample_period - PERIOD_WIDTH'(1)));

  assign start = (state == IDLE) && core_en && (ch_mask != 8'h00) && tick_pending;

  // rr_ptr is one past the last channel written, so the search for the
  // lowest enabled channel starts strictly above it and wraps 7 -> 0.
  always_comb begin
    next_ch  = rr_ptr;
    found    = 1'b0;
    scan_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = rr_ptr + 3'(i);
      if (!found && ch_mask[scan_idx]) begin
        next_ch = scan_idx;
        found   = 1'b1;
      end
    end
  end

  assign ctrl_word = {1'b1, 1'b0, 1'b0, next_ch, 2'b11, 1'b0, 1'b0,
                      adc_range, adc_coding, 4'b0000};

  // Ticks arriving while a frame runs merge into one pending request;
  // a new tick in the start cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
    end else if (!core_en) begin
      period_cnt   <= '0;
      tick_pending <= 1'b0;
    end else begin
      period_cnt   <= tick ? '0 : period_cnt + PERIOD_WIDTH'(1);
      tick_pending <= tick | (tick_pending & ~start);
    end
  end

  // Frame FSM with registered SPI pins and output stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      adc_din      <= 1'b0;
      m_adc_data   <= 12'h000;
      m_adc_chanel <= 3'd0;
      m_axis_valid <= 1'b0;
      busy         <= 1'b0;
      core_en_d    <= 1'b0;
      dummy_cnt    <= 2'd2;
      is_dummy     <= 1'b0;
      rr_ptr       <= 3'd0;
      tx_word      <= 16'h0000;
      rx_word      <= 16'h0000;
      div_cnt      <= 8'd0;
      bit_cnt      <= 5'd0;
      quiet_cnt    <= 8'd0;
`ifdef AD7928_SEQ_ADDR_CHECK_EN
      addr_err     <= 1'b0;
      cur_addr     <= 3'd0;
      prev_addr    <= 3'd0;
      prev_ok      <= 1'b0;
`endif
    end else begin
      m_axis_valid <= 1'b0;
      core_en_d    <= core_en;
`ifdef AD7928_SEQ_ADDR_CHECK_EN
      if (addr_err_clr) addr_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b1;
            busy     <= 1'b1;
            is_dummy <= (dummy_cnt != 2'd0);
            if (dummy_cnt != 2'd0) begin
              adc_din <= 1'b1;
              tx_word <= 16'hFFFE;
            end else begin
              adc_din <= ctrl_word[15];
              tx_word <= {ctrl_word[14:0], 1'b0};
              rr_ptr  <= next_ch + 3'd1;
            end
`ifdef AD7928_SEQ_ADDR_CHECK_EN
            cur_addr <= next_ch;
`endif
          end
        end

        SETUP: begin
          state    <= SHIFT;
          adc_sclk <= 1'b0;
          div_cnt  <= 8'd0;
          bit_cnt  <= 5'd0;
        end

        // Each SCLK period: SCLK_DIV cycles low, then SCLK_DIV high.
        // On the rising edge, capture DOUT and present the next DIN bit.
        // The 16th high phase ends the shift instead of falling again.
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              rx_word  <= {rx_word[14:0], adc_dout};
              adc_din  <= tx_word[15];
              tx_word  <= {tx_word[14:0], 1'b0};
              bit_cnt  <= bit_cnt + 5'd1;
            end else if (bit_cnt == 5'd16) begin
              state <= HOLD;
            end else begin
              adc_sclk <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        HOLD: begin
          state     <= QUIET;
          adc_cs_n  <= 1'b1;
          adc_din   <= 1'b0;
          quiet_cnt <= 8'd1;
          if (is_dummy) begin
            if (dummy_cnt != 2'd0) dummy_cnt <= dummy_cnt - 2'd1;
`ifdef AD7928_SEQ_ADDR_CHECK_EN
            prev_ok <= 1'b0;
`endif
          end else begin
            m_adc_data   <= rx_word[11:0];
            m_adc_chanel <= rx_word[14:12];
            m_axis_valid <= 1'b1;
`ifdef AD7928_SEQ_ADDR_CHECK_EN
            // The word returned after a dummy frame has no known address.
            if (rx_word[15] || (prev_ok && (rx_word[14:12] != prev_addr)))
              addr_err <= 1'b1;
            prev_addr <= cur_addr;
            prev_ok   <= 1'b1;
`endif
          end
        end

        // The IDLE cycle before the next SETUP is also cs_n-high time,
        // so QUIET itself runs one cycle short of QUIET_CYCLES.
        QUIET: begin
          if (quiet_cnt >= QUIET_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            quiet_cnt <= quiet_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase

      // Re-enabling the core restarts the dummy sequence; this overrides a
      // decrement in the same cycle.
      if (core_en && !core_en_d) dummy_cnt <= 2'd2;
    end
  end

endmodule

// File: tb/tb_ad7928_sequencer.sv
// tb_ad7928_sequencer
//
// Directed bench for ad7928_sequencer with a behavioural AD7928 model.
// The model collects each control word on SCLK falling edges and returns
// {0, address of the previous non-dummy write, data_base ^ address}.
// Build with AD7928_SEQ_ADDR_CHECK_EN to also exercise addr_err.

module tb_ad7928_sequencer;

  localparam int SCLK_DIV     = 2;
  localparam int QUIET_CYCLES = 4;
  localparam int PERIOD_WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    core_en = 1'b0;
  logic [7:0]              ch_mask = 8'h00;
  logic [PERIOD_WIDTH-1:0] sample_period = '0;
  logic                    adc_range = 1'b0;
  logic                    adc_coding = 1'b0;
  logic                    adc_cs_n;
  logic                    adc_sclk;
  logic                    adc_din;
  logic                    adc_dout = 1'b0;
  logic [11:0]             m_adc_data;
  logic [2:0]              m_adc_chanel;
  logic                    m_axis_valid;
  logic                    busy;
`ifdef AD7928_SEQ_ADDR_CHECK_EN
  logic                    addr_err;
  logic                    addr_err_clr = 1'b0;
`endif

  ad7928_sequencer #(
    .SCLK_DIV(SCLK_DIV),
    .QUIET_CYCLES(QUIET_CYCLES),
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .core_en(core_en),
    .ch_mask(ch_mask),
    .sample_period(sample_period),
    .adc_range(adc_range),
    .adc_coding(adc_coding),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_din(adc_din),
    .adc_dout(adc_dout),
    .m_adc_data(m_adc_data),
    .m_adc_chanel(m_adc_chanel),
    .m_axis_valid(m_axis_valid),
    .busy(busy)
`ifdef AD7928_SEQ_ADDR_CHECK_EN
    ,
    .addr_err(addr_err),
    .addr_err_clr(addr_err_clr)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ADC model state
  logic [15:0] model_rx;
  logic [15:0] model_out;
  int          model_bits = 0;
  logic [2:0]  model_prev_addr = 3'd0;
  int          force_addr = -1;
  logic [11:0] data_base = 12'h000;
  logic [2:0]  ret_addr;
  logic [15:0] din_words[$];

  // Monitor state
  int          cyc = 0;
  int          fall_cyc = 0;
  logic        prev_cs = 1'b1;
  logic        valid_prev = 1'b0;
  int          double_valid = 0;
  int          low_len = 0;
  int          high_len = 0;
  int          v_cyc[$];
  int          v_lat[$];
  int          v_frame[$];
  logic [2:0]  v_chan[$];
  logic [11:0] v_data[$];
  int          low_lens[$];
  int          high_lens[$];

  // The model latches its reply when chip select falls.
  always @(negedge adc_cs_n) begin
    model_bits = 0;
    model_rx   = 16'h0000;
    ret_addr   = (force_addr >= 0) ? 3'(force_addr) : model_prev_addr;
    model_out  = {1'b0, ret_addr, data_base ^ {9'b0, ret_addr}};
  end

  // On each SCLK fall the ADC samples DIN and presents the next DOUT bit.
  always @(negedge adc_sclk) begin
    if (!adc_cs_n && model_bits < 16) begin
      model_rx   = {model_rx[14:0], adc_din};
      adc_dout   = model_out[15 - model_bits];
      model_bits = model_bits + 1;
    end
  end

  // Only complete frames are recorded; an aborted frame is dropped.
  always @(posedge adc_cs_n) begin
    if (model_bits == 16) begin
      din_words.push_back(model_rx);
      if (model_rx != 16'hFFFF) model_prev_addr = model_rx[12:10];
    end
    model_bits = 0;
  end

  // Samples outputs on the inactive clock edge and logs pulses and
  // chip-select low/high run lengths.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_axis_valid) begin
      v_cyc.push_back(cyc);
      v_chan.push_back(m_adc_chanel);
      v_data.push_back(m_adc_data);
      v_lat.push_back(cyc - fall_cyc);
      v_frame.push_back(din_words.size());
      if (valid_prev) double_valid = double_valid + 1;
    end
    valid_prev = m_axis_valid;
    if (prev_cs && !adc_cs_n) begin
      fall_cyc = cyc;
      high_lens.push_back(high_len);
      low_len = 1;
    end else if (!prev_cs && adc_cs_n) begin
      low_lens.push_back(low_len);
      high_len = 1;
    end else if (adc_cs_n) begin
      high_len = high_len + 1;
    end else begin
      low_len = low_len + 1;
    end
    prev_cs = adc_cs_n;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input int period,
                               input logic rng, input logic cod,
                               input logic [11:0] base, input logic en);
    ch_mask       = mask;
    sample_period = PERIOD_WIDTH'(period);
    adc_range     = rng;
    adc_coding    = cod;
    data_base     = base;
    core_en       = en;
  endtask

  task automatic clearQueues();
    din_words.delete();
    v_cyc.delete();
    v_lat.delete();
    v_frame.delete();
    v_chan.delete();
    v_data.delete();
    low_lens.delete();
    high_lens.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_prev_addr = 3'd0;
    clearQueues();
    reset_n = 1'b1;
  endtask

  task automatic waitValids(input int n, input int budget, input string tag);
    int k = 0;
    while (v_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput(tag, 32'(v_data.size() >= n), 32'd1);
  endtask

  task automatic waitCs(input logic level, input int budget, input string tag);
    int k = 0;
    while (adc_cs_n !== level && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput(tag, 32'(adc_cs_n), 32'(level));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting ad7928_sequencer bench");

    // ---------------- reset state ----------------
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cs_n",  32'(adc_cs_n), 32'd1);
    checkOutput("rst_sclk",  32'(adc_sclk), 32'd1);
    checkOutput("rst_din",   32'(adc_din), 32'd0);
    checkOutput("rst_data",  32'(m_adc_data), 32'd0);
    checkOutput("rst_chan",  32'(m_adc_chanel), 32'd0);
    checkOutput("rst_valid", 32'(m_axis_valid), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
`ifdef AD7928_SEQ_ADDR_CHECK_EN
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
`endif

    // ---------------- single channel, period 200 ----------------
    applyStimulus(8'h01, 200, 1'b1, 1'b0, 12'hABC, 1'b1);
    clearQueues();
    model_prev_addr = 3'd0;
    @(negedge clk);
    reset_n = 1'b1;
    waitValids(3, 2000, "a_wait");
    checkOutput("a_first_frame", 32'(v_frame[0]), 32'd3);
    checkOutput("a_dummy0_din",  32'(din_words[0]), 32'hFFFF);
    checkOutput("a_dummy1_din",  32'(din_words[1]), 32'hFFFF);
    checkOutput("a_ctrl_word",   32'(din_words[2]), 32'h8320);
    checkOutput("a_data0",       32'(v_data[0]), 32'hABC);
    checkOutput("a_chan0",       32'(v_chan[0]), 32'd0);
    checkOutput("a_data2",       32'(v_data[2]), 32'hABC);
    checkOutput("a_interval1",   32'(v_cyc[1] - v_cyc[0]), 32'd200);
    checkOutput("a_interval2",   32'(v_cyc[2] - v_cyc[1]), 32'd200);
    checkOutput("a_latency",     32'(v_lat[0]), 32'd66);
    checkOutput("a_cs_low_len",  32'(low_lens[0]), 32'd66);
    checkOutput("a_cs_low_len2", 32'(low_lens[3]), 32'd66);

    // ---------------- mask A5, back-to-back ----------------
    applyStimulus(8'hA5, 0, 1'b0, 1'b1, 12'h5A0, 1'b1);
    resetDut();
    waitValids(5, 1500, "b_wait");
    checkOutput("b_first_frame", 32'(v_frame[0]), 32'd3);
    checkOutput("b_addr0", 32'(din_words[2][12:10]), 32'd0);
    checkOutput("b_addr1", 32'(din_words[3][12:10]), 32'd2);
    checkOutput("b_word2", 32'(din_words[4]), 32'h9710);
    checkOutput("b_addr3", 32'(din_words[5][12:10]), 32'd7);
    checkOutput("b_addr4", 32'(din_words[6][12:10]), 32'd0);
    checkOutput("b_chan1", 32'(v_chan[1]), 32'd0);
    checkOutput("b_chan2", 32'(v_chan[2]), 32'd2);
    checkOutput("b_chan3", 32'(v_chan[3]), 32'd5);
    checkOutput("b_chan4", 32'(v_chan[4]), 32'd7);
    checkOutput("b_data3", 32'(v_data[3]), 32'h5A5);
    checkOutput("b_data4", 32'(v_data[4]), 32'h5A7);
    checkOutput("b_gap1",  32'(high_lens[1]), 32'd4);
    checkOutput("b_gap5",  32'(high_lens[5]), 32'd4);
    checkOutput("b_frame_pitch", 32'(v_cyc[3] - v_cyc[2]), 32'd70);

    // ---------------- core_en dropped mid-shift ----------------
    waitCs(1'b1, 200, "c_wait_high");
    clearQueues();
    waitCs(1'b0, 200, "c_wait_low");
    repeat (20) @(posedge clk);
    core_en = 1'b0;
    repeat (300) @(posedge clk);
    checkOutput("c_valid_count", 32'(v_data.size()), 32'd1);
    checkOutput("c_frame_count", 32'(low_lens.size()), 32'd1);
    checkOutput("c_frame_len",   32'(low_lens[0]), 32'd66);
    checkOutput("c_busy_idle",   32'(busy), 32'd0);
    checkOutput("c_cs_idle",     32'(adc_cs_n), 32'd1);
    clearQueues();
    core_en = 1'b1;
    waitValids(1, 1000, "c_reen_wait");
    checkOutput("c_reen_first_frame", 32'(v_frame[0]), 32'd3);
    checkOutput("c_reen_dummy0", 32'(din_words[0]), 32'hFFFF);
    checkOutput("c_reen_dummy1", 32'(din_words[1]), 32'hFFFF);

    // ---------------- reset in the 10th shift cycle ----------------
    applyStimulus(8'h01, 0, 1'b1, 1'b0, 12'hABC, 1'b1);
    waitCs(1'b1, 200, "d_wait_high");
    waitCs(1'b0, 200, "d_wait_setup");
    repeat (10) @(posedge clk);
    #2;
    checkOutput("d_sclk_before", 32'(adc_sclk), 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("d_cs_n_async",  32'(adc_cs_n), 32'd1);
    checkOutput("d_sclk_async",  32'(adc_sclk), 32'd1);
    checkOutput("d_valid_async", 32'(m_axis_valid), 32'd0);
    checkOutput("d_busy_async",  32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    model_prev_addr = 3'd0;
    clearQueues();
    reset_n = 1'b1;
    waitValids(1, 1000, "d_wait");
    checkOutput("d_first_frame", 32'(v_frame[0]), 32'd3);
    checkOutput("d_dummy0_din",  32'(din_words[0]), 32'hFFFF);
    checkOutput("d_dummy1_din",  32'(din_words[1]), 32'hFFFF);
    checkOutput("d_ctrl_word",   32'(din_words[2]), 32'h8320);
    checkOutput("d_data",        32'(v_data[0]), 32'hABC);
    checkOutput("d_chan",        32'(v_chan[0]), 32'd0);

`ifdef AD7928_SEQ_ADDR_CHECK_EN
    // ---------------- address mismatch detection ----------------
    applyStimulus(8'h04, 0, 1'b0, 1'b0, 12'hABC, 1'b1);
    resetDut();
    waitValids(2, 1000, "e_wait2");
    @(posedge clk);
    #1;
    checkOutput("e_no_err", 32'(addr_err), 32'd0);
    force_addr = 3;
    waitValids(3, 500, "e_wait3");
    force_addr = -1;
    @(posedge clk);
    #1;
    checkOutput("e_addr_err_set", 32'(addr_err), 32'd1);
    checkOutput("e_bad_chan",     32'(v_chan[2]), 32'd3);
    checkOutput("e_bad_data",     32'(v_data[2]), 32'hABF);
    @(negedge clk);
    addr_err_clr = 1'b1;
    @(negedge clk);
    addr_err_clr = 1'b0;
    checkOutput("e_addr_err_clr", 32'(addr_err), 32'd0);
`endif

    checkOutput("valid_width", 32'(double_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
